// File: rtl/message_scroller_pkg.sv
// message_scroller_pkg
//   Shared encodings and the wrap-around step helper for the message scroller.
//   mode_e : MODE_MANUAL (button steps) / MODE_AUTO (timer steps)
//   dir_e  : DIR_FWD (position +1) / DIR_BWD (position -1)
//   wrap_step(pos, dir, len) : next window position modulo len, valid for
//   any len >= 2 (no power-of-two assumption).

package message_scroller_pkg;

   typedef enum logic {
      MODE_MANUAL = 1'b0,
      MODE_AUTO   = 1'b1
   } mode_e;

   typedef enum logic {
      DIR_FWD = 1'b0,
      DIR_BWD = 1'b1
   } dir_e;

   function automatic int unsigned wrap_step(input int unsigned pos,
                                             input logic        dir,
                                             input int unsigned len);
      if (dir == DIR_BWD) begin
         return (pos == 0) ? len - 1 : pos - 1;
      end
      return (pos >= len - 1) ? 0 : pos + 1;
   endfunction

endpackage

// File: rtl/message_scroller_button.sv
// button_debouncer
//   Two-flop synchroniser, stability counter and rising-edge pulse for a raw
//   push button.  The accepted level follows the synchronised level only after
//   it has disagreed for DEBOUNCE_CYCLES consecutive cycles; an accepted
//   0->1 change yields a single-cycle press pulse (registered).
//   Ports:
//     clk    : rising-edge clock
//     reset  : synchronous, active-low reset
//     button : raw asynchronous button level
//     press  : one-cycle pulse per accepted rising transition

module button_debouncer
   import message_scroller_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic button,
   output logic press
);

   // The counter only ever needs to hold 0 .. DEBOUNCE_CYCLES-1: the cycle on
   // which it would reach DEBOUNCE_CYCLES is the acceptance cycle itself.
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic             level;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync1 <= button;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= sync2;
            cnt   <= '0;
            press <= sync2;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/message_scroller.sv
// message_scroller
//   Latches a MSG_LEN-nibble message and shows a DIGITS-wide wrap-around
//   window onto it.  The window steps on debounced button presses (manual
//   mode) or every SCROLL_PERIOD cycles (auto mode, pausable by a press).
//   Ports:
//     clk     : rising-edge clock
//     reset   : synchronous, active-low reset
//     button  : raw push button
//     mode    : 0 manual, 1 auto
//     dir     : 0 forward, 1 backward
//     load    : one-cycle strobe capturing message (nibble 0 = MS nibble)
//     message : 4*MSG_LEN bit message
//     digits  : 4*DIGITS bit window, leftmost digit = MS nibble
//     pos     : nibble index shown on the leftmost digit
//     paused  : auto-scroll pause flag

module message_scroller
   import message_scroller_pkg::*;
#(
   parameter int DIGITS          = 4,
   parameter int MSG_LEN         = 16,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int SCROLL_PERIOD   = 25000000
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       button,
   input  logic                       mode,
   input  logic                       dir,
   input  logic                       load,
   input  logic [4*MSG_LEN-1:0]       message,
   output logic [4*DIGITS-1:0]        digits,
   output logic [$clog2(MSG_LEN)-1:0] pos,
   output logic                       paused
);

   localparam int POS_W  = $clog2(MSG_LEN);
   localparam int TICK_W = $clog2(SCROLL_PERIOD);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCROLL_PERIOD - 1);
   // One extra bit so pos + i (at most 2*MSG_LEN-2) cannot overflow.
   localparam logic [POS_W:0]    LEN_EXT   = (POS_W + 1)'(MSG_LEN);

   logic [4*MSG_LEN-1:0] shadow;
   logic [TICK_W-1:0]    tick;
   logic                 press;
   logic                 tick_hit;
   logic                 step;
   logic [3:0]           nib [MSG_LEN];

   button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_button (
      .clk    (clk),
      .reset  (reset),
      .button (button),
      .press  (press)
   );

   assign tick_hit = (mode == MODE_AUTO) && !paused && (tick == TICK_LAST);
   assign step     = (mode == MODE_AUTO) ? tick_hit : press;

   always_ff @(posedge clk) begin
      if (!reset) begin
         shadow <= '0;
         pos    <= '0;
         tick   <= '0;
         paused <= 1'b0;
      end else begin
         if (load) begin
            shadow <= message;
            pos    <= '0;
         end else if (step) begin
            pos <= POS_W'(wrap_step(32'(pos), dir, MSG_LEN));
         end

         if (load || (mode == MODE_MANUAL) || tick_hit) begin
            tick <= '0;
         end else if (!paused) begin
            tick <= tick + TICK_W'(1);
         end

         // paused can only be set in auto mode, so clearing it on every
         // manual cycle is the same as clearing it on the auto->manual switch.
         if (mode == MODE_MANUAL) begin
            paused <= 1'b0;
         end else if (press) begin
            paused <= ~paused;
         end
      end
   end

   for (genvar k = 0; k < MSG_LEN; k++) begin : g_nib
      assign nib[k] = shadow[4*(MSG_LEN-1-k) +: 4];
   end

   for (genvar i = 0; i < DIGITS; i++) begin : g_win
      logic [POS_W:0]   sum;
      logic [POS_W-1:0] idx;
      assign sum = {1'b0, pos} + (POS_W + 1)'(i);
      assign idx = POS_W'((sum >= LEN_EXT) ? sum - LEN_EXT : sum);
      assign digits[4*(DIGITS-1-i) +: 4] = nib[idx];
   end

endmodule

// File: tb/tb_message_scroller.sv
// tb_message_scroller
//   Self-checking bench for message_scroller (DIGITS=4, MSG_LEN=16,
//   DEBOUNCE_CYCLES=4, SCROLL_PERIOD=8).  A cycle-level behavioural model
//   predicts digits/pos/paused; directed scenarios pin literal values and a
//   randomized phase exercises mixed stimulus.

module tb_message_scroller;

   localparam int DIGITS  = 4;
   localparam int MSG_LEN = 16;
   localparam int DEB     = 4;
   localparam int PERIOD  = 8;
   localparam logic [63:0] MSG = 64'h0123456789ABCDEF;

   logic        clk     = 1'b0;
   logic        reset   = 1'b0;
   logic        button  = 1'b0;
   logic        mode    = 1'b0;
   logic        dir     = 1'b0;
   logic        load    = 1'b0;
   logic [63:0] message = MSG;
   logic [15:0] digits;
   logic [3:0]  pos;
   logic        paused;

   int   total    = 0;
   int   bad      = 0;
   logic check_en = 1'b0;

   always #5 clk = ~clk;

   message_scroller #(
      .DIGITS          (DIGITS),
      .MSG_LEN         (MSG_LEN),
      .DEBOUNCE_CYCLES (DEB),
      .SCROLL_PERIOD   (PERIOD)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .button  (button),
      .mode    (mode),
      .dir     (dir),
      .load    (load),
      .message (message),
      .digits  (digits),
      .pos     (pos),
      .paused  (paused)
   );

   // Model state after each edge.  b1/b2 are the button as seen one and two
   // edges ago; run counts consecutive samples disagreeing with the accepted
   // level; press is the pulse that acts on the following edge.
   typedef struct packed {
      logic [63:0] shadow;
      int          pos;
      int          tick;
      logic        paused;
      logic        prev_mode;
      logic        b1;
      logic        b2;
      logic        acc;
      int          run;
      logic        press;
   } mstate_t;

   mstate_t m = '0;

   function automatic logic [3:0] nib_of(input logic [63:0] s, input int k);
      return 4'((s >> (4 * (15 - k))) & 64'hF);
   endfunction

   function automatic logic [15:0] window_of(input logic [63:0] s, input int p);
      logic [15:0] w;
      w = '0;
      for (int i = 0; i < DIGITS; i++) begin
         w = {w[11:0], nib_of(s, (p + i) % MSG_LEN)};
      end
      return w;
   endfunction

   function automatic mstate_t model_next(input mstate_t c, input logic rst_n,
                                          input logic btn, input logic md,
                                          input logic dr, input logic ld,
                                          input logic [63:0] msg);
      mstate_t n;
      logic    seen;
      logic    do_step;
      if (!rst_n) return '0;
      n       = c;
      do_step = 1'b0;
      seen    = c.b2;
      n.b2    = c.b1;
      n.b1    = btn;
      if (md) begin
         if (!c.paused) begin
            if (c.tick == PERIOD - 1) begin
               n.tick  = 0;
               do_step = 1'b1;
            end else begin
               n.tick = c.tick + 1;
            end
         end
         if (c.press) n.paused = !c.paused;
      end else begin
         n.tick  = 0;
         do_step = c.press;
         if (c.prev_mode) n.paused = 1'b0;
      end
      n.prev_mode = md;
      if (ld) begin
         n.shadow = msg;
         n.pos    = 0;
         n.tick   = 0;
      end else if (do_step) begin
         n.pos = dr ? (c.pos + MSG_LEN - 1) % MSG_LEN : (c.pos + 1) % MSG_LEN;
      end
      n.press = 1'b0;
      if (seen != c.acc) begin
         n.run = c.run + 1;
         if (n.run == DEB) begin
            n.acc   = seen;
            n.run   = 0;
            n.press = seen;
         end
      end else begin
         n.run = 0;
      end
      return n;
   endfunction

   always @(posedge clk) m <= model_next(m, reset, button, mode, dir, load, message);

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         check("model_digits", 64'(digits), 64'(window_of(m.shadow, m.pos)));
         check("model_pos", 64'(pos), 64'(m.pos));
         check("model_paused", 64'(paused), 64'(m.paused));
      end
   end

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press_btn();
      button = 1'b1;
      wait_n(8);
      button = 1'b0;
      wait_n(8);
   endtask

   initial begin
      int   p0;
      int   adv;
      logic found;

      // 1. reset and first load
      reset = 1'b0;
      wait_n(5);
      check_en = 1'b1;
      check("rst_digits", 64'(digits), 64'h0);
      check("rst_pos", 64'(pos), 64'h0);
      check("rst_paused", 64'(paused), 64'h0);
      reset = 1'b1;
      load  = 1'b1;
      wait_n(1);
      load = 1'b0;
      check("load_digits", 64'(digits), 64'h0123);
      check("load_pos", 64'(pos), 64'h0);

      // 2. manual press latency, held button, glitch
      button = 1'b1;
      wait_n(6);
      check("lat6_pos", 64'(pos), 64'h0);
      wait_n(1);
      check("lat7_digits", 64'(digits), 64'h1234);
      check("lat7_pos", 64'(pos), 64'h1);
      wait_n(5);
      button = 1'b0;
      wait_n(10);
      check("held_pos", 64'(pos), 64'h1);
      button = 1'b1;
      wait_n(2);
      button = 1'b0;
      wait_n(12);
      check("glitch_pos", 64'(pos), 64'h1);

      // 3. wrap both directions
      repeat (12) press_btn();
      check("pos13_digits", 64'(digits), 64'hDEF0);
      press_btn();
      check("fwd_digits", 64'(digits), 64'hEF01);
      check("fwd_pos", 64'(pos), 64'd14);
      repeat (2) press_btn();
      check("wrap0_digits", 64'(digits), 64'h0123);
      dir = 1'b1;
      press_btn();
      check("bwd_pos", 64'(pos), 64'd15);
      check("bwd_digits", 64'(digits), 64'hF012);
      dir = 1'b0;

      // 4. auto scroll, pause, resume
      mode = 1'b1;
      load = 1'b1;
      wait_n(1);
      load = 1'b0;
      wait_n(7);
      check("auto7_pos", 64'(pos), 64'h0);
      wait_n(1);
      check("auto8_digits", 64'(digits), 64'h1234);
      wait_n(8);
      check("auto16_digits", 64'(digits), 64'h2345);
      press_btn();
      check("pause_set", 64'(paused), 64'h1);
      p0 = m.pos;
      wait_n(40);
      check("pause_frozen_pos", 64'(pos), 64'(p0));
      check("pause_still", 64'(paused), 64'h1);
      press_btn();
      check("pause_clear", 64'(paused), 64'h0);
      wait_n(24);
      adv = (int'(pos) - p0 + MSG_LEN) % MSG_LEN;
      check("resumed_adv", 64'(adv >= 3), 64'h1);

      // 5. load coinciding with a tick at pos 5
      found = 1'b0;
      for (int c = 0; c < 300 && !found; c++) begin
         if (m.pos == 5 && m.tick == PERIOD - 1) found = 1'b1;
         else wait_n(1);
      end
      check("reach_pos5_tick", 64'(found), 64'h1);
      if (found) begin
         load = 1'b1;
         wait_n(1);
         load = 1'b0;
         check("ldtick_pos", 64'(pos), 64'h0);
         check("ldtick_digits", 64'(digits), 64'h0123);
         wait_n(7);
         check("ldtick_hold", 64'(pos), 64'h0);
         wait_n(1);
         check("ldtick_step", 64'(pos), 64'h1);
      end

      // 6. tick and press together at pos 8->9, then reset while paused
      found = 1'b0;
      for (int c = 0; c < 300 && !found; c++) begin
         if (m.pos == 8 && m.tick == 1 && !m.paused) found = 1'b1;
         else wait_n(1);
      end
      check("reach_pos8", 64'(found), 64'h1);
      button = 1'b1;
      wait_n(7);
      check("coinc_pos", 64'(pos), 64'd9);
      check("coinc_paused", 64'(paused), 64'h1);
      check("coinc_digits", 64'(digits), 64'h9ABC);
      reset = 1'b0;
      mode  = 1'b0;
      wait_n(1);
      check("midrst_pos", 64'(pos), 64'h0);
      check("midrst_paused", 64'(paused), 64'h0);
      check("midrst_digits", 64'(digits), 64'h0);
      reset = 1'b1;
      wait_n(10);
      check("held_thru_rst_pos", 64'(pos), 64'h1);
      button = 1'b0;
      wait_n(10);

      // randomized phase
      message = MSG;
      load    = 1'b1;
      wait_n(1);
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 9) == 0) button = ~button;
         if ($urandom_range(0, 199) == 0) mode = ~mode;
         if ($urandom_range(0, 99) == 0) dir = ~dir;
         load = ($urandom_range(0, 149) == 0);
         if (load) message = {$urandom, $urandom};
         reset = ($urandom_range(0, 599) != 0);
         wait_n(1);
      end
      reset = 1'b1;
      load  = 1'b0;
      wait_n(2);
      check_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
